// File: rtl/bootram_bus_ctrl.sv
// bootram_bus_ctrl: boot RAM bus controller with post-reset byte-stream image loader
module bootram_bus_ctrl #(
    parameter int ADDR_W  = 11,
    parameter bit LOAD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_rdata,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_done,
    output logic [ADDR_W+1:0] ld_count,
    output logic [3:0]        ram_ce,
    output logic              ram_wre,
    output logic              ram_oce,
    output logic              ram_reset,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);
    typedef enum logic [1:0] {LOAD, IDLE, ACCESS, RESP} state_t;
    state_t state, state_n;
    logic [ADDR_W+1:0] ptr;
    logic [31:0] rdata_q;
    logic wr_q, ld_acc, ld_fin, req, unused;
    assign ld_count  = ptr;
    assign ram_reset = ~resetn;
    assign mem_rdata = (mem_ready && !wr_q) ? ram_dout : rdata_q;
    assign unused    = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};
    // next-state: loader finishes on ld_last or when the byte pointer wraps
    always_comb begin
        state_n = state;
        ld_acc  = ld_valid & ld_ready;
        ld_fin  = ld_acc & (ld_last | (&ptr));
        req     = (state == IDLE) & mem_valid;
        case (state)
            LOAD:    state_n = ld_fin ? IDLE : LOAD;
            IDLE:    state_n = mem_valid ? ACCESS : IDLE;
            ACCESS:  state_n = RESP;
            default: state_n = IDLE;
        endcase
    end
    // state, loader bookkeeping and registered RAM command
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= LOAD_EN ? LOAD : IDLE;
            ptr       <= '0;
            ld_done   <= !LOAD_EN;
            ld_ready  <= 1'b0;
            mem_ready <= 1'b0;
            wr_q      <= 1'b0;
            rdata_q   <= '0;
            ram_ce    <= '0;
            ram_wre   <= 1'b0;
            ram_oce   <= 1'b0;
            ram_ad    <= '0;
            ram_din   <= '0;
        end else begin
            state     <= state_n;
            ld_ready  <= state_n == LOAD;
            mem_ready <= state == ACCESS;
            ram_oce   <= 1'b1;
            ram_ce    <= ld_acc ? 4'b0001 << ptr[1:0] : req ? ((|mem_wstrb) ? mem_wstrb : 4'hF) : 4'h0;
            ram_wre   <= ld_acc | (req & (|mem_wstrb));
            if (ld_acc) begin
                ptr     <= ptr + 1'b1;
                ram_ad  <= ptr[ADDR_W+1:2];
                ram_din <= {4{ld_data}};
            end else if (req) begin
                ram_ad  <= mem_addr[ADDR_W+1:2];
                ram_din <= mem_wdata;
                wr_q    <= |mem_wstrb;
            end
            if (ld_fin) ld_done <= 1'b1;
            if (state == RESP && !wr_q) rdata_q <= ram_dout;
        end
    end
endmodule

// File: tb/tb_bootram_bus_ctrl.sv
// tb_bootram_bus_ctrl: directed self-checking bench with a behavioural byte-lane RAM
module tb_bootram_bus_ctrl;
    localparam int AW = 11;
    logic clk = 1'b0, resetn = 1'b0;
    logic mem_valid = 1'b0, mem_ready;
    logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
    logic [3:0] mem_wstrb = '0;
    logic ld_valid = 1'b0, ld_ready, ld_last = 1'b0, ld_done;
    logic [7:0] ld_data = '0;
    logic [AW+1:0] ld_count;
    logic [3:0] ram_ce;
    logic ram_wre, ram_oce, ram_reset;
    logic [AW-1:0] ram_ad;
    logic [31:0] ram_din, ram_dout = '0;
    logic [31:0] mem [2048];
    int errs = 0, checks = 0, rdy_cnt = 0, rc0 = 0, lat = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    bootram_bus_ctrl #(.ADDR_W(AW), .LOAD_EN(1'b1)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .ld_done(ld_done), .ld_count(ld_count), .ram_ce(ram_ce), .ram_wre(ram_wre),
        .ram_oce(ram_oce), .ram_reset(ram_reset), .ram_ad(ram_ad), .ram_din(ram_din),
        .ram_dout(ram_dout));

    always @(posedge clk) begin
        if (ram_ce != 4'h0) begin
            if (ram_wre) begin
                for (int i = 0; i < 4; i++)
                    if (ram_ce[i]) mem[ram_ad][8*i +: 8] <= ram_din[8*i +: 8];
            end else begin
                ram_dout <= mem[ram_ad];
            end
        end
    end

    always @(negedge clk) if (mem_ready) rdy_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        ld_valid = 1'b0;
        mem_valid = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        logic acc;
        acc = 1'b0;
        ld_valid = 1'b1;
        ld_data = b;
        ld_last = last;
        for (int n = 0; n < 20 && !acc; n++) begin
            acc = ld_ready;
            tick();
        end
        if (!acc) chk("ld_accept_timeout", 32'd0, 32'd1);
        ld_valid = 1'b0;
        ld_last = 1'b0;
    endtask

    task automatic cpu(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                       output logic [31:0] rdv, output int l);
        logic got;
        got = 1'b0;
        mem_valid = 1'b1;
        mem_addr = a;
        mem_wdata = wd;
        mem_wstrb = st;
        l = 0;
        for (int n = 0; n < 12 && !got; n++) begin
            tick();
            l++;
            got = mem_ready;
        end
        if (!got) l = 99;
        rdv = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        tick();
        tick();
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_ld_count", ld_count, 0);
        chk("rst_ld_done", ld_done, 0);
        chk("rst_ram_ce", ram_ce, 0);
        chk("rst_ram_wre", ram_wre, 0);
        chk("rst_ram_oce", ram_oce, 0);
        chk("rst_ram_ad", ram_ad, 0);
        chk("rst_ram_reset", ram_reset, 1);
        resetn = 1'b1;
        tick();
        chk("ld_ready_up", ld_ready, 1);
        chk("ram_oce_up", ram_oce, 1);
        chk("ram_reset_low", ram_reset, 0);
        send(8'h13, 1'b0);
        chk("t1_ce_lane0", ram_ce, 4'b0001);
        chk("t1_wre", ram_wre, 1);
        chk("t1_din", ram_din, 32'h13131313);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        chk("t1_notdone", ld_done, 0);
        send(8'h6F, 1'b1);
        chk("t1_ce_w1", ram_ce, 4'b0001);
        chk("t1_ad_w1", ram_ad, 1);
        chk("t1_done", ld_done, 1);
        chk("t1_count", ld_count, 5);
        chk("t1_ld_ready_off", ld_ready, 0);
        tick();
        chk("t1_word0", mem[0], 32'h00000013);
        chk("t1_word1", mem[1], 32'h0000006F);
        cpu(32'h0, 32'h0, 4'h0, rd, lat);
        chk("t2_latency", lat, 2);
        chk("t2_rdata", rd, 32'h00000013);
        tick();
        chk("t2_ready_1cyc", mem_ready, 0);
        chk("t2_rdata_hold", mem_rdata, 32'h00000013);
        cpu(32'h4, 32'hAABBCCDD, 4'b0101, rd, lat);
        chk("t3_wr_latency", lat, 2);
        chk("t3_wr_rdata_kept", rd, 32'h00000013);
        tick();
        cpu(32'h4, 32'h0, 4'h0, rd, lat);
        chk("t3_rdata", rd, 32'h00BB00DD);
        tick();
        do_reset();
        mem_valid = 1'b1;
        mem_addr = 32'h0;
        mem_wstrb = 4'h0;
        rc0 = rdy_cnt;
        send(8'h11, 1'b0);
        tick();
        chk("t4_gap_ce", ram_ce, 0);
        tick();
        send(8'h22, 1'b0);
        tick();
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        chk("t4_no_ready_load", rdy_cnt - rc0, 0);
        chk("t4_done", ld_done, 1);
        chk("t4_count", ld_count, 4);
        lat = 0;
        for (int n = 0; n < 10 && !mem_ready; n++) begin
            tick();
            lat++;
        end
        chk("t4_ready_seen", mem_ready, 1);
        chk("t4_rdata", mem_rdata, 32'h44332211);
        mem_valid = 1'b0;
        tick();
        tick();
        do_reset();
        for (int i = 0; i < 8192; i++) begin
            send(8'(i), 1'b0);
            if (i == 8190) chk("t5_not_done_early", ld_done, 0);
        end
        chk("t5_done", ld_done, 1);
        chk("t5_count_wrap", ld_count, 0);
        chk("t5_ld_ready_off", ld_ready, 0);
        chk("t5_last_ad", ram_ad, 11'h7FF);
        chk("t5_last_ce", ram_ce, 4'b1000);
        tick();
        chk("t5_lane3_7ff", mem[11'h7FF][31:24], 8'hFF);
        cpu(32'h1FFC, 32'h0, 4'h0, rd, lat);
        chk("t5_rd_top", rd, 32'hFFFEFDFC);
        tick();
        cpu(32'h5FFC, 32'h0, 4'h0, rd, lat);
        chk("t5_rd_alias", rd, 32'hFFFEFDFC);
        tick();
        cpu(32'h0, 32'h0, 4'h0, rd, lat);
        chk("t5_rd_w0", rd, 32'h03020100);
        tick();
        mem_valid = 1'b1;
        mem_addr = 32'h0;
        mem_wstrb = 4'h0;
        rc0 = rdy_cnt;
        tick();
        resetn = 1'b0;
        tick();
        chk("t6_ram_reset", ram_reset, 1);
        chk("t6_ready_low", mem_ready, 0);
        chk("t6_ce_low", ram_ce, 0);
        mem_valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        chk("t6_in_load", ld_ready, 1);
        chk("t6_ld_done", ld_done, 0);
        chk("t6_ld_count", ld_count, 0);
        chk("t6_rdata_clr", mem_rdata, 0);
        chk("t6_no_ready", rdy_cnt - rc0, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
